// File: rtl/paleta_pkg.sv
// Shared definitions for the writable cube colour palette: default RGB565
// colours, sweep state encoding and the default-colour lookup.
package paleta_pkg;

  localparam logic [15:0] BRANCO   = 16'h4AAB;
  localparam logic [15:0] VERMELHO = 16'h6000;
  localparam logic [15:0] LARANJA  = 16'hE800;
  localparam logic [15:0] AMARELO  = 16'h5343;
  localparam logic [15:0] VERDE    = 16'h03E5;
  localparam logic [15:0] AZUL     = 16'h180A;

  localparam int NUM_CORES = 6;

  typedef enum logic {
    INIT,
    IDLE
  } state_t;

  // Entries past the six cube colours load as black.
  function automatic logic [15:0] default_color(input int unsigned idx);
    logic [15:0] color;
    case (idx)
      0:       color = BRANCO;
      1:       color = VERMELHO;
      2:       color = LARANJA;
      3:       color = AMARELO;
      4:       color = VERDE;
      5:       color = AZUL;
      default: color = 16'h0000;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/paleta_init_fsm.sv
// Init sweep controller: walks every palette entry once after reset or a
// restore request and drives the default colour into the storage array.
module paleta_init_fsm
  import paleta_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             restore,
  output logic             busy,
  output logic             init_we,
  output logic [AW-1:0]    init_addr,
  output logic [WIDTH-1:0] init_data
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] cnt;

  // A restore in either state restarts the sweep from entry 0.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= INIT;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (restore) begin
      state <= INIT;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (state == INIT) begin
      if (cnt == LAST) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign init_we   = (state == INIT);
  assign init_addr = cnt;
  assign init_data = WIDTH'(default_color(32'(cnt)));

endmodule

// File: rtl/paleta_cores.sv
// Writable colour palette with a default-load sweep, one arbitrated write port
// and NUM_RD independent registered read ports.
module paleta_cores
  import paleta_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int NUM_RD = 2,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    restore,
  output logic                    busy,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [WIDTH-1:0]        wdata,
  output logic                    wr_err,
  input  logic [NUM_RD-1:0]       rd_en,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_valid
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             init_we;
  logic [AW-1:0]    init_addr;
  logic [WIDTH-1:0] init_data;
  logic             waddr_ok;
  logic             wr_ok;
  logic             rd_allowed;

  paleta_init_fsm #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_init_fsm (
    .clk       (clk),
    .clear     (clear),
    .restore   (restore),
    .busy      (busy),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  assign waddr_ok   = ({1'b0, waddr} < DEPTH_W);
  assign wr_ok      = we & ~busy & ~restore & waddr_ok;
  assign rd_allowed = ~busy & ~restore;

  // User writes can only land in IDLE, so they never collide with the sweep.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= we & ~wr_ok;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]    addr;
    logic             addr_ok;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    assign addr    = rd_addr[i*AW +: AW];
    assign addr_ok = ({1'b0, addr} < DEPTH_W);

    // Write-first: a same-cycle write to the read address forwards wdata.
    always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_en[i] & rd_allowed;
        if (rd_en[i] & rd_allowed) begin
          if (!addr_ok) begin
            data_q <= '0;
          end else if (wr_ok && (waddr == addr)) begin
            data_q <= wdata;
          end else begin
            data_q <= mem[addr];
          end
        end
      end
    end

    assign rd_data[i*WIDTH +: WIDTH] = data_q;
    assign rd_valid[i]               = valid_q;
  end

endmodule
